// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shifter.
//   - shift_op_e : operation encodings seen on ctrl_op
//   - state_e    : controller states
//   - WIDTH, BIG_STEP, AMT_W : datapath width, coarse step size, amount width
package shifter_pkg;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned BIG_STEP = 8;
    localparam int unsigned AMT_W    = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Amount consumed by one step: the coarse stride or a single bit.
    function automatic logic [AMT_W-1:0] step_amount(input logic big);
        return big ? AMT_W'(BIG_STEP) : AMT_W'(1);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of the iterative shifter.
//   acc_i : current working value
//   op_i  : operation (SLL/SRL/SRA/ROR)
//   big_i : 1 = shift by BIG_STEP bits, 0 = shift by one bit
//   acc_o : shifted value
module shift_step
    import shifter_pkg::*;
(
    input  logic [WIDTH-1:0] acc_i,
    input  shift_op_e        op_i,
    input  logic             big_i,
    output logic [WIDTH-1:0] acc_o
);

    always_comb begin
        acc_o = acc_i;
        if (big_i) begin
            case (op_i)
                OP_SLL: acc_o = {acc_i[WIDTH-BIG_STEP-1:0], {BIG_STEP{1'b0}}};
                OP_SRL: acc_o = {{BIG_STEP{1'b0}}, acc_i[WIDTH-1:BIG_STEP]};
                // acc[31] still holds the original sign at every step.
                OP_SRA: acc_o = {{BIG_STEP{acc_i[WIDTH-1]}}, acc_i[WIDTH-1:BIG_STEP]};
                OP_ROR: acc_o = {acc_i[BIG_STEP-1:0], acc_i[WIDTH-1:BIG_STEP]};
            endcase
        end else begin
            case (op_i)
                OP_SLL: acc_o = {acc_i[WIDTH-2:0], 1'b0};
                OP_SRL: acc_o = {1'b0, acc_i[WIDTH-1:1]};
                OP_SRA: acc_o = {acc_i[WIDTH-1], acc_i[WIDTH-1:1]};
                OP_ROR: acc_o = {acc_i[0], acc_i[WIDTH-1:1]};
            endcase
        end
    end

endmodule

// File: rtl/multicycle_shifter.sv
// Iterative 32-bit shifter: shifts by 8 bits per cycle while at least 8
// remain, then by 1 bit per cycle. Request and result use valid/ready.
//   clock, reset_n          : clock, asynchronous active-low reset
//   in_valid / in_ready     : request handshake (accepted only in IDLE)
//   data_operandA           : value to shift
//   ctrl_shiftamt           : shift amount 0-31
//   ctrl_op                 : 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   out_valid / out_ready   : result handshake (held in DONE until taken)
//   data_result             : shifted value (working register)
//   busy                    : high while in SHIFT
// All outputs are registers or state decodes; no input-to-output paths.
module multicycle_shifter
    import shifter_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [AMT_W-1:0] ctrl_shiftamt,
    input  logic [1:0]       ctrl_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    shift_op_e        op_q, op_d;

    logic             big;
    logic [WIDTH-1:0] step_acc;

    assign big = (rem_q >= AMT_W'(BIG_STEP));

    shift_step u_step (
        .acc_i (acc_q),
        .op_i  (op_q),
        .big_i (big),
        .acc_o (step_acc)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            op_q    <= OP_SLL;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                // in_ready is the IDLE decode, so in_valid alone completes the handshake.
                if (in_valid) begin
                    acc_d   = data_operandA;
                    rem_d   = ctrl_shiftamt;
                    op_d    = shift_op_e'(ctrl_op);
                    state_d = (ctrl_shiftamt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                acc_d = step_acc;
                rem_d = rem_q - step_amount(big);
                if (rem_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q == SHIFT);
    assign out_valid   = (state_q == DONE);
    assign data_result = acc_q;

endmodule

// File: tb/tb_multicycle_shifter.sv
module tb_multicycle_shifter;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_operandA;
    logic [4:0]  ctrl_shiftamt;
    logic [1:0]  ctrl_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_result;
    logic        busy;

    multicycle_shifter dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_operandA (data_operandA),
        .ctrl_shiftamt (ctrl_shiftamt),
        .ctrl_op       (ctrl_op),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .data_result   (data_result),
        .busy          (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] exp;
        int unsigned lat;
        int unsigned c0;
    } sb_t;

    sb_t sb[$];

    int unsigned passed = 0;
    int unsigned total  = 0;

    // 0: out_ready high, 1: out_ready low, 2: random stalls
    int unsigned or_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        total++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] s,
                                              input logic [1:0] op);
        logic [63:0] t;
        case (op)
            2'b00:   return a << s;
            2'b01:   return a >> s;
            2'b10:   return $signed(a) >>> s;
            default: begin
                t = {a, a} >> s;
                return t[31:0];
            end
        endcase
    endfunction

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: samples at the falling edge, pops on a completed result handshake.
    logic        seen = 1'b0;
    logic [31:0] held;
    int unsigned busy_cnt = 0;

    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                seen     = 1'b0;
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (out_valid) begin
                    chk("in_ready_in_done", 32'(in_ready), 32'd0);
                    if (!seen) begin
                        seen = 1'b1;
                        held = data_result;
                        if (sb.size() == 0) begin
                            total++;
                            $display("FAIL unexpected_result: got %h expected none", data_result);
                        end else begin
                            chk("result", data_result, sb[0].exp);
                            chk("latency", cyc - sb[0].c0, sb[0].lat);
                            chk("busy_cycles", busy_cnt, sb[0].lat - 1);
                        end
                    end else begin
                        chk("result_stable", data_result, held);
                    end
                    if (out_ready) begin
                        if (sb.size() != 0) void'(sb.pop_front());
                        seen     = 1'b0;
                        busy_cnt = 0;
                    end
                end
            end
        end
    end

    // Called at posedge+1. noise toggles in_valid with garbage while waiting.
    task automatic send(input logic [31:0] a, input logic [4:0] s, input logic [1:0] op,
                        input logic [31:0] exp, input bit noise);
        int unsigned w = 0;
        sb_t e;
        while (!in_ready && w < 200) begin
            if (noise) begin
                in_valid      = 1'($urandom_range(0, 1));
                data_operandA = $urandom;
                ctrl_shiftamt = 5'($urandom);
                ctrl_op       = 2'($urandom);
            end
            @(posedge clock);
            #1;
            w++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            timeout("wait_in_ready");
            return;
        end
        data_operandA = a;
        ctrl_shiftamt = s;
        ctrl_op       = op;
        in_valid      = 1'b1;
        e.exp = exp;
        e.lat = 1 + int'(s) / 8 + int'(s) % 8;
        e.c0  = cyc;
        sb.push_back(e);
        @(posedge clock);
        #1;
        in_valid      = 1'b0;
        data_operandA = $urandom;
        ctrl_shiftamt = 5'($urandom);
        ctrl_op       = 2'($urandom);
    endtask

    task automatic drain();
        int unsigned w = 0;
        while ((sb.size() != 0 || !in_ready) && w < 400) begin
            @(posedge clock);
            #1;
            w++;
        end
        if (sb.size() != 0 || !in_ready) timeout("drain");
    endtask

    typedef struct {
        logic [31:0] a;
        logic [4:0]  s;
        logic [1:0]  op;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$] = '{
        '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF},
        '{32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678},
        '{32'h0000_0101, 5'd9,  2'b11, 32'h8080_0000},
        '{32'h0000_0101, 5'd9,  2'b01, 32'h0000_0000},
        '{32'hF000_0000, 5'd8,  2'b01, 32'h00F0_0000},
        '{32'h7FFF_FFFF, 5'd16, 2'b10, 32'h0000_7FFF},
        '{32'hFFFF_FFFF, 5'd31, 2'b00, 32'h8000_0000},
        '{32'h1234_5678, 5'd16, 2'b11, 32'h5678_1234},
        '{32'h8000_0000, 5'd0,  2'b10, 32'h8000_0000},
        '{32'h0000_0001, 5'd1,  2'b11, 32'h8000_0000},
        '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001},
        '{32'h8765_4321, 5'd7,  2'b10, 32'hFF0E_CA86}
    };

    initial begin
        int unsigned w;
        logic [31:0] ra;
        logic [4:0]  rs;
        logic [1:0]  rop;

        reset_n       = 1'b0;
        in_valid      = 1'b0;
        data_operandA = '0;
        ctrl_shiftamt = '0;
        ctrl_op       = '0;

        #2;
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy",      32'(busy),      32'd0);
        chk("reset_result",    data_result,    32'h0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Directed vectors, back-to-back
        foreach (vecs[i]) send(vecs[i].a, vecs[i].s, vecs[i].op, vecs[i].exp, 1'b0);
        drain();

        // Back-pressure: result held while out_ready is low, in_valid pulses ignored
        or_mode = 1;
        send(32'h0000_0001, 5'd12, 2'b00, 32'h0000_1000, 1'b0);
        w = 0;
        while (!out_valid && w < 50) begin
            @(posedge clock);
            #1;
            w++;
        end
        if (!out_valid) timeout("wait_out_valid");
        repeat (5) begin
            in_valid      = 1'b1;
            data_operandA = $urandom;
            ctrl_shiftamt = 5'($urandom);
            ctrl_op       = 2'($urandom);
            @(posedge clock);
            #1;
            in_valid = 1'b0;
        end
        or_mode = 0;
        drain();

        // Reset on the second SHIFT cycle discards the operation
        send(32'hFFFF_FFFF, 5'd20, 2'b01, 32'h0000_0FFF, 1'b0);
        @(posedge clock);
        #1;
        chk("busy_before_reset", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy",      32'(busy),      32'd0);
        chk("midrst_result",    data_result,    32'h0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        send(32'h0000_0001, 5'd4, 2'b00, 32'h0000_0010, 1'b0);
        drain();

        // Random requests with random stalls, checked against the reference function
        or_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            ra  = $urandom;
            rs  = 5'($urandom_range(0, 31));
            rop = 2'($urandom_range(0, 3));
            send(ra, rs, rop, ref_shift(ra, rs, rop), 1'b1);
        end
        in_valid = 1'b0;
        drain();
        or_mode = 0;

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
